// File: rtl/sign_reducer_pkg.sv
// Shared widths and the result payload for the sign reducer.
//   DATA_BUS_WIDTH  : width of the word being reduced
//   IMMEDIATE_WIDTH : target immediate width (must be < DATA_BUS_WIDTH)
//   WIDTH_BITS      : width of the min_width result (>= clog2(DATA_BUS_WIDTH+1))
package sign_reducer_pkg;

  localparam int unsigned DATA_BUS_WIDTH  = 16;
  localparam int unsigned IMMEDIATE_WIDTH = 12;
  localparam int unsigned WIDTH_BITS      = 5;
  localparam int unsigned IDX_BITS        = $clog2(DATA_BUS_WIDTH);

  // Result of one reduction; held until the next completed scan.
  typedef struct packed {
    logic [WIDTH_BITS-1:0]      min_width;
    logic                       fits;
    logic [IMMEDIATE_WIDTH-1:0] imm;
  } reduce_result_t;

  // Build the result for a given minimal width and captured word.
  function automatic reduce_result_t make_result(
    input logic [WIDTH_BITS-1:0]     width,
    input logic [DATA_BUS_WIDTH-1:0] word
  );
    reduce_result_t r;
    r.min_width = width;
    r.fits      = (width <= WIDTH_BITS'(IMMEDIATE_WIDTH));
    r.imm       = word[IMMEDIATE_WIDTH-1:0];
    return r;
  endfunction

endpackage

// File: rtl/sign_reducer.sv
// Serial minimal-signed-width finder (inverse of immediate sign extension).
// Scans one bit per clock from just below the sign bit downwards and stops at
// the first bit differing from the sign bit.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : request, sampled only while idle
//   din        : word to reduce, captured on the accepted start edge
//   busy       : high while scanning
//   done       : one-cycle pulse, results valid from this cycle
//   min_width  : minimal signed width, 1..DATA_BUS_WIDTH
//   fits       : min_width <= IMMEDIATE_WIDTH
//   imm_out    : low IMMEDIATE_WIDTH bits of the captured word
module sign_reducer
  import sign_reducer_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [DATA_BUS_WIDTH-1:0]  din,
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH_BITS-1:0]      min_width,
  output logic                       fits,
  output logic [IMMEDIATE_WIDTH-1:0] imm_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    state, state_n;
  logic [DATA_BUS_WIDTH-1:0] din_r, din_n;
  logic [WIDTH_BITS-1:0]     idx, idx_n;
  logic                      busy_n, done_n;
  reduce_result_t            res, res_n;
  logic                      bit_differs;

  // Current scanned bit versus the sign bit.
  assign bit_differs = din_r[idx[IDX_BITS-1:0]] != din_r[DATA_BUS_WIDTH-1];

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      din_r <= '0;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      res   <= '0;
    end else begin
      state <= state_n;
      din_r <= din_n;
      idx   <= idx_n;
      busy  <= busy_n;
      done  <= done_n;
      res   <= res_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n = state;
    din_n   = din_r;
    idx_n   = idx;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    res_n   = res;
    unique case (state)
      IDLE: begin
        if (start) begin
          din_n   = din;
          idx_n   = WIDTH_BITS'(DATA_BUS_WIDTH - 2);
          busy_n  = 1'b1;
          state_n = SCAN;
        end
      end
      SCAN: begin
        if (bit_differs) begin
          // Width includes the differing bit plus one sign bit above it.
          res_n   = make_result(idx + WIDTH_BITS'(2), din_r);
          done_n  = 1'b1;
          state_n = DONE;
        end else if (idx == '0) begin
          res_n   = make_result(WIDTH_BITS'(1), din_r);
          done_n  = 1'b1;
          state_n = DONE;
        end else begin
          idx_n  = idx - WIDTH_BITS'(1);
          busy_n = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign min_width = res.min_width;
  assign fits      = res.fits;
  assign imm_out   = res.imm;

endmodule

// File: tb/tb_sign_reducer.sv
// Scoreboard bench for sign_reducer: the driver pushes hand-computed results,
// a monitor pops and compares on every done pulse.
module tb_sign_reducer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] din;
  logic        busy;
  logic        done;
  logic [4:0]  min_width;
  logic        fits;
  logic [11:0] imm_out;

  typedef struct {
    logic [4:0]  w;
    logic        f;
    logic [11:0] imm;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   busy_cnt = 0;

  sign_reducer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .din       (din),
    .busy      (busy),
    .done      (done),
    .min_width (min_width),
    .fits      (fits),
    .imm_out   (imm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every done pulse against the oldest expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (busy && done) check("busy_and_done", 1, 0);
      if (busy) busy_cnt++;
      if (done) begin
        if (q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("min_width", int'(min_width), int'(e.w));
          check("fits", int'(fits), int'(e.f));
          if (e.f) check("imm_out", int'(imm_out), int'(e.imm));
          check("scan_cycles", busy_cnt, e.cyc);
        end
        busy_cnt = 0;
      end
    end
  end

  // Issue one start, optionally disturb inputs mid-scan, and wait for done.
  task automatic run(input logic [15:0] d, input logic [4:0] w, input logic f,
                     input logic [11:0] imm, input int cyc,
                     input bit hold_start, input bit toggle_din,
                     input bit start_in_done);
    exp_t e;
    bit   seen;
    logic [4:0] prev_w;
    prev_w = min_width;
    e.w = w; e.f = f; e.imm = imm; e.cyc = cyc;
    q.push_back(e);
    @(negedge clk);
    din   = d;
    start = 1'b1;
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    if (toggle_din) begin
      din = ~d;
      check("hold_during_scan", int'(min_width), int'(prev_w));
    end
    seen = done;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (toggle_din) din = 16'(din + 16'h1357);
      seen = done;
    end
    if (!seen) check("done_timeout", 0, 1);
    start = start_in_done ? 1'b1 : 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_after_done", int'(busy), 0);
    check("queue_drained", q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    din   = 16'h0;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_min_width", int'(min_width), 0);
    check("rst_fits", int'(fits), 0);
    check("rst_imm", int'(imm_out), 0);
    rst_n = 1'b1;
    @(negedge clk);

    //   din       width fits imm      cyc
    run(16'h0005, 5'd4,  1'b1, 12'h005, 13, 0, 0, 0);
    run(16'hFFFF, 5'd1,  1'b1, 12'hFFF, 15, 0, 0, 0);
    run(16'h0000, 5'd1,  1'b1, 12'h000, 15, 0, 0, 0);
    run(16'h4000, 5'd16, 1'b0, 12'h000, 1,  0, 0, 0);
    run(16'hF800, 5'd12, 1'b1, 12'h800, 5,  0, 0, 0);
    run(16'hF7FF, 5'd13, 1'b0, 12'h7FF, 4,  0, 0, 0);
    run(16'h07FF, 5'd12, 1'b1, 12'h7FF, 5,  0, 0, 0);
    run(16'h8000, 5'd16, 1'b0, 12'h000, 1,  0, 0, 0);
    run(16'h0800, 5'd13, 1'b0, 12'h800, 4,  0, 0, 0);
    // Protocol: start held through scan, din toggled mid-scan, start in DONE.
    run(16'hFC21, 5'd11, 1'b1, 12'hC21, 6,  1, 0, 0);
    run(16'h0005, 5'd4,  1'b1, 12'h005, 13, 0, 1, 0);
    run(16'h0100, 5'd10, 1'b1, 12'h100, 7,  0, 0, 1);

    // Asynchronous reset in the middle of a scan.
    @(negedge clk);
    din   = 16'hFFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_min_width", int'(min_width), 0);
    check("abort_fits", int'(fits), 0);
    check("abort_imm", int'(imm_out), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(16'hFFF0, 5'd5, 1'b1, 12'hFF0, 12, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
